// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative unsigned multiply / restoring divide unit.
// Runs one operation per accepted start over WIDTH cycles and reports
// the result with a single-cycle done pulse. Multiply and divide share
// one 2*WIDTH work register and one captured-operand register.
module mdu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       operation,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;    // {acc, multiplier} or {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;    // multiplicand or divisor
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     div_shift_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   div_rem_s;
  logic [2*WIDTH-1:0] div_next_s;

  // One shift-add multiply step and one restoring divide step on work_q.
  always_comb begin
    mul_sum_s   = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    if (work_q[0]) begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    end else begin
      mul_sum_s = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    end
    mul_next_s  = {mul_sum_s, work_q[WIDTH-1:1]};

    div_shift_s = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, opnd_q});
    // When the trial subtraction succeeds the difference is below the
    // divisor, so the low WIDTH bits hold it exactly.
    div_rem_s   = div_shift_s[WIDTH-1:0] - opnd_q;
    if (div_ge_s) begin
      div_next_s = {div_rem_s, work_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sequencer next-state, operand capture and result loading.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start && (operation == OP_MUL)) begin
          state_d = S_MUL;
          cnt_d   = {CW{1'b0}};
          work_d  = {{WIDTH{1'b0}}, b};
          opnd_d  = a;
          dbz_d   = 1'b0;
        end else if (start && (operation == OP_DIV)) begin
          if (b != {WIDTH{1'b0}}) begin
            state_d = S_DIV;
            cnt_d   = {CW{1'b0}};
            work_d  = {{WIDTH{1'b0}}, a};
            opnd_d  = b;
            dbz_d   = 1'b0;
          end else begin
            state_d  = S_DONE;
            res_lo_d = {WIDTH{1'b1}};
            res_hi_d = a;
            dbz_d    = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        work_d = mul_next_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_STEP) begin
          state_d  = S_DONE;
          res_hi_d = mul_next_s[2*WIDTH-1:WIDTH];
          res_lo_d = mul_next_s[WIDTH-1:0];
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        work_d = div_next_s;
        cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_STEP) begin
          state_d  = S_DONE;
          res_hi_d = div_next_s[2*WIDTH-1:WIDTH];
          res_lo_d = div_next_s[WIDTH-1:0];
        end else begin
          state_d = S_DIV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_MUL) || (state_d == S_DIV);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and registered outputs; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      work_q   <= {(2*WIDTH){1'b0}};
      opnd_q   <= {WIDTH{1'b0}};
      res_lo_q <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer (WIDTH=16): directed operations
// with literal expectations plus a cycle-level reference model.
module tb_mdu_sequencer;

  localparam int W = 16;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0001;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   operation;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mdu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .operation(operation), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: busy for 16 cycles after an accepted mult/div, then a
  // done cycle carrying a*b or {a%b, a/b}; divide by zero finishes at once.
  int          m_busy_left;
  logic        m_done, m_dbz;
  logic [31:0] m_pend;
  logic [15:0] m_lo, m_hi;

  // Model update at the same edge the DUT samples.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_lo   <= 16'h0;
      m_hi   <= 16'h0;
      m_pend <= 32'h0;
    end else if (m_busy_left > 0) begin
      m_busy_left <= m_busy_left - 1;
      if (m_busy_left == 1) begin
        m_done <= 1'b1;
        m_lo   <= m_pend[15:0];
        m_hi   <= m_pend[31:16];
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start && operation == OP_MUL) begin
      m_busy_left <= W;
      m_pend <= {16'h0, a} * {16'h0, b};
      m_dbz  <= 1'b0;
    end else if (start && operation == OP_DIV && b != 16'h0) begin
      m_busy_left <= W;
      m_pend <= {a % b, a / b};
      m_dbz  <= 1'b0;
    end else if (start && operation == OP_DIV) begin
      m_done <= 1'b1;
      m_lo   <= 16'hFFFF;
      m_hi   <= a;
      m_dbz  <= 1'b1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'h0, busy}, {31'h0, m_busy_left != 0});
      chk("cyc_done", {31'h0, done}, {31'h0, m_done});
      chk("cyc_dbz",  {31'h0, div_by_zero}, {31'h0, m_dbz});
      chk("cyc_busy_done_excl", {31'h0, busy & done}, 32'h0);
      if (m_busy_left == 0) begin
        chk("cyc_lo", {16'h0, result_lo}, {16'h0, m_lo});
        chk("cyc_hi", {16'h0, result_hi}, {16'h0, m_hi});
      end
    end
  end

  // Issue one operation and check latency, busy length and result literals.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [15:0] ia, input logic [15:0] ib,
                        input logic [15:0] elo, input logic [15:0] ehi,
                        input logic edbz, input int elat, input int ebusy,
                        input bit disturb);
    int lat;
    int busyc;
    @(negedge clk);
    operation = op; a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    if (!disturb) start = 1'b0;
    lat = 1;
    busyc = 0;
    while (!done && lat < 40) begin
      if (busy) busyc++;
      if (disturb) begin
        a = 16'($urandom);
        b = 16'($urandom);
        operation = OP_DIV;
      end
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_cycles"}, busyc, ebusy);
    chk({name, "_lo"}, {16'h0, result_lo}, {16'h0, elo});
    chk({name, "_hi"}, {16'h0, result_hi}, {16'h0, ehi});
    chk({name, "_dbz"}, {31'h0, div_by_zero}, {31'h0, edbz});
    if (disturb) begin
      operation = OP_MUL;
      a = 16'h7;
      b = 16'h7;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b1; start = 1'b0; operation = 4'h0; a = 16'h0; b = 16'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_lo", {16'h0, result_lo}, 32'h0);
    chk("rst_hi", {16'h0, result_hi}, 32'h0);
    chk("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_op("mul_300x200", OP_MUL, 16'd300, 16'd200, 16'hEA60, 16'h0000, 1'b0, 17, 16, 1'b0);
    run_op("mul_max", OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 17, 16, 1'b0);
    run_op("div_100_7", OP_DIV, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 16, 1'b0);
    run_op("div_5_9", OP_DIV, 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 17, 16, 1'b0);
    run_op("div_max_1", OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 17, 16, 1'b0);
    run_op("div_by_zero", OP_DIV, 16'h04D2, 16'h0000, 16'hFFFF, 16'h04D2, 1'b1, 1, 0, 1'b0);
    run_op("mul_after_dbz", OP_MUL, 16'd3, 16'd5, 16'd15, 16'd0, 1'b0, 17, 16, 1'b0);

    // Request with a non-multicycle opcode must be ignored.
    @(negedge clk);
    operation = OP_ADD; a = 16'h1234; b = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (20) begin
      if (busy || done) cnt++;
      @(negedge clk);
    end
    chk("ignored_op_activity", cnt, 0);
    chk("ignored_op_lo", {16'h0, result_lo}, 32'd15);

    // Start pulses and operand changes during the multiply are ignored.
    run_op("mul_disturbed", OP_MUL, 16'd1234, 16'd56, 16'h0DF0, 16'h0001, 1'b0, 17, 16, 1'b1);

    // Reset in cycle 8 of a divide.
    @(negedge clk);
    operation = OP_DIV; a = 16'd100; b = 16'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    chk("midrst_lo", {16'h0, result_lo}, 32'h0);
    chk("midrst_hi", {16'h0, result_hi}, 32'h0);
    chk("midrst_dbz", {31'h0, div_by_zero}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      if (busy || done) cnt++;
      @(negedge clk);
    end
    chk("post_reset_no_done", cnt, 0);
    run_op("mul_3x4_after_rst", OP_MUL, 16'd3, 16'd4, 16'd12, 16'd0, 1'b0, 17, 16, 1'b0);

    // Back-to-back issue at the earliest accepted slot.
    run_op("b2b_div", OP_DIV, 16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, 17, 16, 1'b0);
    run_op("b2b_mul", OP_MUL, 16'd255, 16'd257, 16'hFFFF, 16'h0000, 1'b0, 17, 16, 1'b0);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
